// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: opcode/handshake inputs and datapath control outputs of the multicycle control unit
// master: control FSM side (drives controls, reads op/mem_ready); slave: datapath side
interface mc_ctrl_if;
   logic [5:0] op;
   logic       mem_ready;
   logic       iord, irwrite, memwrite, regwrite, alusrca, extop;
   logic       pcwrite, branch, branch_ne, illegal;
   logic [1:0] memtoreg, regdst, alusrcb, pcsrc;
   logic [2:0] aluop;
   logic [3:0] state_o;
   modport master (
      input  op, mem_ready,
      output iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca, alusrcb,
             aluop, extop, pcsrc, pcwrite, branch, branch_ne, illegal, state_o
   );
   modport slave (
      output op, mem_ready,
      input  iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca, alusrcb,
             aluop, extop, pcsrc, pcwrite, branch, branch_ne, illegal, state_o
   );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control FSM (fetch/decode/execute/memory/writeback, trap on illegal op)
// ports: clk, reset (sync, active-low), bus (mc_ctrl_if.master: op/mem_ready in, datapath controls + state_o out)
module mc_ctrl_fsm #(
   parameter bit ENABLE_BNE    = 1'b1,
   parameter bit ENABLE_JAL    = 1'b1,
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input logic       clk,
   input logic       reset,
   mc_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
      MEMWR = 4'd5, REXEC = 4'd6, RWB = 4'd7, BEQ = 4'd8, IEXEC = 4'd9,
      IWB = 4'd10, JUMP = 4'd11, BNE = 4'd12, JAL = 4'd13, TRAP = 4'd14
   } state_t;
   state_t     state_q, state_d;
   logic       rdy, imm_zext;
   logic [2:0] imm_aluop;
   always_comb begin
      rdy       = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
      imm_zext  = bus.op == 6'b001100 || bus.op == 6'b001101;
      imm_aluop = bus.op == 6'b001010 ? 3'b101 :
                  bus.op == 6'b001100 ? 3'b011 :
                  bus.op == 6'b001101 ? 3'b100 : 3'b000;
      state_d       = FETCH;
      bus.iord      = 1'b0;
      bus.irwrite   = 1'b0;
      bus.memwrite  = 1'b0;
      bus.memtoreg  = 2'b00;
      bus.regdst    = 2'b00;
      bus.regwrite  = 1'b0;
      bus.alusrca   = 1'b0;
      bus.alusrcb   = 2'b00;
      bus.aluop     = 3'b000;
      bus.extop     = 1'b0;
      bus.pcsrc     = 2'b00;
      bus.pcwrite   = 1'b0;
      bus.branch    = 1'b0;
      bus.branch_ne = 1'b0;
      bus.illegal   = 1'b0;
      // with reset low every output stays at its zero default and the FSM returns to FETCH
      if (reset) begin
         case (state_q)
            FETCH: begin
               bus.alusrcb = 2'b01;
               bus.irwrite = rdy;
               bus.pcwrite = rdy;
               state_d     = rdy ? DECODE : FETCH;
            end
            DECODE: begin
               bus.alusrcb = 2'b11;
               case (bus.op)
                  6'b000000:                                    state_d = REXEC;
                  6'b100011, 6'b101011:                         state_d = MEMADR;
                  6'b000100:                                    state_d = BEQ;
                  6'b000101:                                    state_d = ENABLE_BNE ? BNE : TRAP;
                  6'b001000, 6'b001010, 6'b001100, 6'b001101:   state_d = IEXEC;
                  6'b000010:                                    state_d = JUMP;
                  6'b000011:                                    state_d = ENABLE_JAL ? JAL : TRAP;
                  default:                                      state_d = TRAP;
               endcase
            end
            MEMADR: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = 2'b10;
               state_d     = bus.op == 6'b101011 ? MEMWR : MEMRD;
            end
            MEMRD: begin
               bus.iord = 1'b1;
               state_d  = rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
               bus.regwrite = 1'b1;
               bus.memtoreg = 2'b01;
            end
            MEMWR: begin
               bus.iord     = 1'b1;
               bus.memwrite = 1'b1;
               state_d      = rdy ? FETCH : MEMWR;
            end
            REXEC: begin
               bus.alusrca = 1'b1;
               bus.aluop   = 3'b010;
               state_d     = RWB;
            end
            RWB: begin
               bus.regwrite = 1'b1;
               bus.regdst   = 2'b01;
            end
            IEXEC: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = 2'b10;
               bus.aluop   = imm_aluop;
               bus.extop   = imm_zext;
               state_d     = IWB;
            end
            IWB: begin
               bus.regwrite = 1'b1;
               bus.aluop    = imm_aluop;
               bus.extop    = imm_zext;
            end
            BEQ, BNE: begin
               bus.alusrca   = 1'b1;
               bus.aluop     = 3'b001;
               bus.pcsrc     = 2'b01;
               bus.branch    = state_q == BEQ;
               bus.branch_ne = state_q == BNE;
            end
            JUMP: begin
               bus.pcsrc   = 2'b10;
               bus.pcwrite = 1'b1;
            end
            JAL: begin
               bus.pcsrc    = 2'b10;
               bus.pcwrite  = 1'b1;
               bus.regwrite = 1'b1;
               bus.regdst   = 2'b10;
               bus.memtoreg = 2'b10;
            end
            // TRAP and the unused code 15 hold until reset
            default: begin
               bus.illegal = 1'b1;
               state_d     = state_q;
            end
         endcase
      end
      bus.state_o = reset ? state_q : 4'd0;
   end
   always_ff @(posedge clk) state_q <= state_d;
endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Parametrised multicycle control unit for the MIPS core: a registered-state FSM that sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select. Compared with the first-generation main decoder, it adds BNE, JAL, ANDI/ORI/SLTI, a memory ready/wait handshake, an illegal-opcode trap state, and fully defined outputs in every state. It sits between the instruction register opcode field and the multicycle datapath/ALU decoder.

## Interface
Parameters:
- ENABLE_BNE, default 1: BNE (000101) supported; when 0 it is an illegal op.
- ENABLE_JAL, default 1: JAL (000011) supported; when 0 it is an illegal op.
- MEM_HANDSHAKE, default 1: FETCH, MEMRD and MEMWR wait on mem_ready; when 0, mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-low; clock clk.
- op  in  6  opcode from the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  instruction register load.
- memwrite  out  1  memory write strobe.
- memtoreg  out  2  register write data: 00 = ALUOut, 01 = MDR, 10 = PC.
- regdst  out  2  destination register: 00 = rt, 01 = rd, 10 = r31.
- regwrite  out  1  register file write.
- alusrca  out  1  ALU A: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B: 00 = register B, 01 = 4, 10 = sign/zero-extended immediate, 11 = shifted immediate.
- aluop  out  3  000 add, 001 sub, 010 use funct, 011 and, 100 or, 101 slt.
- extop  out  1  1 = zero-extend the immediate (ANDI/ORI); 0 = sign-extend.
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcwrite  out  1  unconditional PC load.
- branch  out  1  PC load if zero.
- branch_ne  out  1  PC load if not zero.
- illegal  out  1  high while the FSM is in TRAP.
- state_o  out  4  current state, for debug.

## Operation
- State register, 4 bits. Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7, BEQ 8, IEXEC 9, IWB 10, JUMP 11, BNE 12, JAL 13, TRAP 14. Code 15 is unreachable and behaves as TRAP.
- Every output defaults to 0 in every state. Only the values listed below are non-zero, so there are no latches and no held-over values from the previous state.
- Transitions:
  - FETCH goes to DECODE when mem_ready=1; otherwise it holds.
  - DECODE dispatches on op:
    - 000000 → REXEC
    - 100011 and 101011 → MEMADR
    - 000100 → BEQ
    - 000101 → BNE
    - 001000, 001010, 001100, 001101 → IEXEC
    - 000010 → JUMP
    - 000011 → JAL
    - any other op, or a parameter-disabled op → TRAP
  - MEMADR goes to MEMRD for LW and to MEMWR for SW.
  - MEMRD goes to MEMWB when mem_ready=1; otherwise it holds.
  - MEMWR goes to FETCH when mem_ready=1; otherwise it holds.
  - REXEC → RWB and IEXEC → IWB.
  - MEMWB, RWB, IWB, BEQ, BNE, JUMP and JAL each go to FETCH.
  - TRAP holds until reset.
- Outputs per state:
  - FETCH: alusrcb=01, irwrite = pcwrite = mem_ready (the PC and IR load only on the ready cycle).
  - DECODE: alusrcb=11 (branch target into ALUOut).
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: regwrite=1, memtoreg=01, regdst=00.
  - MEMWR: iord=1, memwrite=1 (held high through the wait cycles).
  - REXEC: alusrca=1, aluop=010.
  - RWB: regwrite=1, regdst=01.
  - IEXEC: alusrca=1, alusrcb=10. aluop is 000 for ADDI, 101 for SLTI, 011 for ANDI, 100 for ORI. extop=1 for ANDI and ORI.
  - IWB: regwrite=1, regdst=00. It keeps the same extop/aluop as IEXEC, decoded from op.
  - BEQ: alusrca=1, aluop=001, pcsrc=01, branch=1.
  - BNE: the same as BEQ, but branch_ne=1 instead of branch.
  - JUMP: pcsrc=10, pcwrite=1.
  - JAL: pcsrc=10, pcwrite=1, regwrite=1, regdst=10, memtoreg=10. The PC already holds PC+4 at this point.
  - TRAP: illegal=1 and every other output is 0.
- op must stay stable from DECODE until the instruction returns to FETCH. The IR does not change because irwrite=0 outside FETCH.

## Timing
- Reset:
  - While reset=0, every output is forced to 0 combinationally (including irwrite, pcwrite and illegal) and state_o=0.
  - At the first rising edge with reset=0, the state becomes FETCH. Reset mid-instruction or in TRAP abandons the instruction, and no strobe fires on that cycle.
- Cycles per instruction with no wait states: LW 5; SW, R-type and I-arith 4; BEQ, BNE, J and JAL 3.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. With MEM_HANDSHAKE=0 there are never wait cycles.
- The next state and all outputs are a function of the registered state and the current op/mem_ready. The only combinational input-to-output paths are mem_ready → irwrite/pcwrite and op → aluop/extop.

## Test plan
- Reset held low for 3 cycles, then released with op=000000 and mem_ready=1 → all outputs 0 during reset; state_o sequence 0,1,6,7,0; regwrite=1 and regdst=01 only in RWB.
- LW (100011) with mem_ready=0 for 2 cycles in FETCH and 1 cycle in MEMRD → state sequence 0,0,0,1,2,3,3,4,0; irwrite pulses exactly once; memtoreg=01 in MEMWB.
- SW (101011) with mem_ready low for 2 cycles in MEMWR → memwrite=1 for 3 consecutive cycles, and iord=1 throughout.
- BNE, then ANDI (001100) → BNE: branch_ne=1, branch=0, aluop=001. ANDI: extop=1 and aluop=011 in both IEXEC and IWB.
- JAL with ENABLE_JAL=1 → state 13 for one cycle with pcsrc=10, regdst=10, memtoreg=10, pcwrite=1, regwrite=1. With ENABLE_JAL=0 → state 14 and illegal=1 held until reset=0.
- Op 111111 in DECODE → TRAP, with every strobe 0 for 10 cycles. Then reset=0 for one cycle → state 0 and illegal=0.
